// File: rtl/wgt_buf_pkg.sv
// Shared types and config helpers for the double-buffered weight store.
package wgt_buf_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL,
    DRAINING
  } bank_state_t;

  function automatic int unsigned eff_len(input int unsigned len, input int unsigned depth);
    return (len == 0) ? depth : len;
  endfunction

  function automatic int unsigned eff_rep(input int unsigned rep);
    return (rep == 0) ? 1 : rep;
  endfunction

endpackage

// File: rtl/wgt_buf_bank.sv
// One weight bank: DEPTH x LINE_W registers, indexed write, combinational read.
module wgt_bank #(
  parameter int LINE_W = 512,
  parameter int DEPTH  = 16,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [LINE_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic [LINE_W-1:0] rdata
);

  logic [LINE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/wgt_pingpong_buffer.sv
// Ping-pong weight buffer: one bank fills from the Share Master while the
// other is replayed to the MAC array a programmable number of passes.
module wgt_pingpong_buffer
  import wgt_buf_pkg::*;
#(
  parameter int LINE_W = 512,
  parameter int DEPTH  = 16,
  parameter int REP_W  = 8,
  localparam int LEN_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LEN_W-1:0]  CfgLen_i,
  input  logic [REP_W-1:0]  CfgRepeat_i,
  input  logic              Flush_i,
  input  logic [LINE_W-1:0] ShareMstLine_i,
  input  logic              ShareMstValid_i,
  output logic              ShareMstReady_o,
  input  logic              MacReady_i,
  output logic [LINE_W-1:0] Weight0_o,
  output logic              WeightValid_o,
  output logic              WeightLast_o,
  output logic [1:0]        BankFull_o,
  output logic              DropErr_o
);

  localparam int IDX_W = $clog2(DEPTH);

  bank_state_t       st_q [2], st_n [2];
  logic [LEN_W-1:0]  len_q [2], len_n [2];
  logic [REP_W-1:0]  rep_q [2], rep_n [2];
  logic              wr_bank_q, wr_bank_n, rd_bank_q, rd_bank_n;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_n, rd_idx_q, rd_idx_n;
  logic [REP_W-1:0]  pass_q, pass_n;
  logic              drop_q, drop_n;
  logic [LEN_W-1:0]  cfg_len, cur_len, rd_len;
  logic [REP_W-1:0]  cfg_rep, rd_rep;
  logic              accept, consume, valid;
  logic [LINE_W-1:0] rdata0, rdata1;

  assign cfg_len = LEN_W'(eff_len(32'(CfgLen_i), DEPTH));
  assign cfg_rep = REP_W'(eff_rep(32'(CfgRepeat_i)));

  assign ShareMstReady_o = !(st_q[wr_bank_q] inside {FULL, DRAINING});
  assign valid           = st_q[rd_bank_q] inside {FULL, DRAINING};
  assign accept          = ShareMstValid_i && ShareMstReady_o;
  assign consume         = MacReady_i && valid;
  assign rd_len          = len_q[rd_bank_q];
  assign rd_rep          = rep_q[rd_bank_q];

  wgt_bank #(.LINE_W(LINE_W), .DEPTH(DEPTH)) u_bank0 (
    .clk   (clk),
    .we    (accept && !wr_bank_q),
    .widx  (wr_idx_q),
    .wdata (ShareMstLine_i),
    .ridx  (rd_idx_q),
    .rdata (rdata0)
  );

  wgt_bank #(.LINE_W(LINE_W), .DEPTH(DEPTH)) u_bank1 (
    .clk   (clk),
    .we    (accept && wr_bank_q),
    .widx  (wr_idx_q),
    .wdata (ShareMstLine_i),
    .ridx  (rd_idx_q),
    .rdata (rdata1)
  );

  // Data is gated so the output reads as zero whenever nothing is valid.
  assign Weight0_o     = valid ? (rd_bank_q ? rdata1 : rdata0) : '0;
  assign WeightValid_o = valid;
  assign WeightLast_o  = valid && (LEN_W'(rd_idx_q) == rd_len - LEN_W'(1))
                               && (pass_q == rd_rep - REP_W'(1));
  assign BankFull_o    = {st_q[1] inside {FULL, DRAINING}, st_q[0] inside {FULL, DRAINING}};
  assign DropErr_o     = drop_q;

  always_comb begin
    st_n      = st_q;
    len_n     = len_q;
    rep_n     = rep_q;
    wr_bank_n = wr_bank_q;
    rd_bank_n = rd_bank_q;
    wr_idx_n  = wr_idx_q;
    rd_idx_n  = rd_idx_q;
    pass_n    = pass_q;
    drop_n    = drop_q | (ShareMstValid_i & ~ShareMstReady_o);
    cur_len   = len_q[wr_bank_q];

    if (accept) begin
      if (st_q[wr_bank_q] == EMPTY) begin
        len_n[wr_bank_q] = cfg_len;
        rep_n[wr_bank_q] = cfg_rep;
        cur_len          = cfg_len;
      end
      if (LEN_W'(wr_idx_q) == cur_len - LEN_W'(1)) begin
        st_n[wr_bank_q] = FULL;
        wr_idx_n        = '0;
        wr_bank_n       = ~wr_bank_q;
      end else begin
        st_n[wr_bank_q] = FILLING;
        wr_idx_n        = wr_idx_q + IDX_W'(1);
      end
    end

    // Fill and drain never target the same bank, so both updates may apply.
    if (consume) begin
      if (LEN_W'(rd_idx_q) < rd_len - LEN_W'(1)) begin
        rd_idx_n        = rd_idx_q + IDX_W'(1);
        st_n[rd_bank_q] = DRAINING;
      end else if (pass_q < rd_rep - REP_W'(1)) begin
        rd_idx_n        = '0;
        pass_n          = pass_q + REP_W'(1);
        st_n[rd_bank_q] = DRAINING;
      end else begin
        st_n[rd_bank_q] = EMPTY;
        rd_idx_n        = '0;
        pass_n          = '0;
        rd_bank_n       = ~rd_bank_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || Flush_i) begin
      for (int unsigned k = 0; k < 2; k++) begin
        st_q[k]  <= EMPTY;
        len_q[k] <= '0;
        rep_q[k] <= '0;
      end
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      pass_q    <= '0;
      drop_q    <= 1'b0;
    end else begin
      st_q      <= st_n;
      len_q     <= len_n;
      rep_q     <= rep_n;
      wr_bank_q <= wr_bank_n;
      rd_bank_q <= rd_bank_n;
      wr_idx_q  <= wr_idx_n;
      rd_idx_q  <= rd_idx_n;
      pass_q    <= pass_n;
      drop_q    <= drop_n;
    end
  end

endmodule

// File: tb/tb_wgt_pingpong_buffer.sv
// Scoreboard bench: tiles are modelled as line lists expanded into an expected
// beat queue; a negedge monitor compares the DUT against it.
module tb_wgt_pingpong_buffer;

  localparam int LINE_W = 512;
  localparam int DEPTH  = 16;
  localparam int REP_W  = 8;
  localparam int LEN_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [LEN_W-1:0]  cfg_len = '0;
  logic [REP_W-1:0]  cfg_rep = '0;
  logic              flush = 1'b0;
  logic [LINE_W-1:0] sm_line = '0;
  logic              sm_valid = 1'b0;
  logic              sm_ready;
  logic              mac_ready = 1'b0;
  logic [LINE_W-1:0] weight;
  logic              w_valid, w_last;
  logic [1:0]        bank_full;
  logic              drop_err;

  wgt_pingpong_buffer #(.LINE_W(LINE_W), .DEPTH(DEPTH), .REP_W(REP_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .CfgLen_i        (cfg_len),
    .CfgRepeat_i     (cfg_rep),
    .Flush_i         (flush),
    .ShareMstLine_i  (sm_line),
    .ShareMstValid_i (sm_valid),
    .ShareMstReady_o (sm_ready),
    .MacReady_i      (mac_ready),
    .Weight0_o       (weight),
    .WeightValid_o   (w_valid),
    .WeightLast_o    (w_last),
    .BankFull_o      (bank_full),
    .DropErr_o       (drop_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LINE_W-1:0] line;
    logic              last;
  } beat_t;

  beat_t             exp_q [$];
  logic [LINE_W-1:0] tile [$];
  int unsigned       tile_len, tile_rep, pending;
  logic              drop_m, rel_flag, check_en;
  int                tests = 0, fails = 0;

  task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [LINE_W-1:0] rnd_line();
    logic [LINE_W-1:0] l;
    for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    tile.delete();
    pending  = 0;
    drop_m   = 1'b0;
    rel_flag = 1'b0;
  endtask

  // One clock cycle: drive inputs just after a rising edge, advance the model
  // with what the edge will do, then wait for the edge.
  task automatic step(input logic v, input logic [LINE_W-1:0] ln, input logic m,
                      input logic fl, input logic r, output logic acc);
    logic done, clr, drop_set;
    done = 1'b0;
    sm_valid = v; sm_line = ln; mac_ready = m; flush = fl; rst = r;
    clr      = fl | r;
    acc      = v && !clr && (pending < 2);
    drop_set = v && !clr && (pending >= 2);
    if (acc) begin
      if (tile.size() == 0) begin
        tile_len = (cfg_len == 0) ? DEPTH : int'(cfg_len);
        tile_rep = (cfg_rep == 0) ? 1 : int'(cfg_rep);
      end
      tile.push_back(ln);
      done = (tile.size() == tile_len);
    end
    @(posedge clk);
    #1;
    if (done) begin
      for (int unsigned p = 0; p < tile_rep; p++)
        for (int unsigned i = 0; i < tile_len; i++)
          exp_q.push_back('{tile[i], (p == tile_rep - 1) && (i == tile_len - 1)});
      tile.delete();
      pending++;
    end
    if (rel_flag) begin
      pending--;
      rel_flag = 1'b0;
    end
    if (drop_set) drop_m = 1'b1;
    if (clr) model_clear();
  endtask

  task automatic idle(input int n, input logic m);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, '0, m, 1'b0, 1'b0, a);
  endtask

  // Source that only presents a line while the buffer can take it.
  task automatic send(input logic [LINE_W-1:0] ln, input logic m, output int nacc);
    logic a;
    a = 1'b0;
    nacc = 0;
    for (int i = 0; i < 4 && !a; i++) begin
      step(pending < 2, ln, m, 1'b0, 1'b0, a);
      if (a) nacc = 1;
    end
  endtask

  initial begin
    check_en = 1'b0;
    forever begin
      @(negedge clk);
      if (check_en) begin
        chk("ready", {511'b0, sm_ready}, {511'b0, pending < 2});
        chk("valid", {511'b0, w_valid}, {511'b0, exp_q.size() > 0});
        chk("bankfull_cnt", LINE_W'($countones(bank_full)), LINE_W'(pending));
        chk("droperr", {511'b0, drop_err}, {511'b0, drop_m});
        if (exp_q.size() > 0) begin
          chk("weight", weight, exp_q[0].line);
          chk("last", {511'b0, w_last}, {511'b0, exp_q[0].last});
          if (mac_ready && !flush && !rst) begin
            if (exp_q[0].last) rel_flag = 1'b1;
            void'(exp_q.pop_front());
          end
        end else begin
          chk("weight_idle", weight, '0);
          chk("last_idle", {511'b0, w_last}, '0);
        end
      end
    end
  end

  initial begin
    logic a;
    int   n, total;
    logic [LINE_W-1:0] hold;
    logic have;
    model_clear();
    cfg_len = LEN_W'(4); cfg_rep = REP_W'(1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, a);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, a);
    check_en = 1'b1;

    // Single pass of four lines.
    for (int i = 0; i < 4; i++) send(LINE_W'(32'hA0 + i), 1'b1, n);
    idle(6, 1'b1);

    // Two lines replayed three times.
    cfg_len = LEN_W'(2); cfg_rep = REP_W'(3);
    send(LINE_W'(32'hB0), 1'b1, n);
    send(LINE_W'(32'hB1), 1'b1, n);
    idle(8, 1'b1);

    // Both banks fill with the MAC stalled; the source is held off after eight lines.
    cfg_len = LEN_W'(4); cfg_rep = REP_W'(1);
    total = 0;
    for (int i = 0; i < 12; i++) begin
      step(pending < 2, LINE_W'(32'hC0 + total), 1'b0, 1'b0, 1'b0, a);
      if (a) total++;
    end
    chk("accepted_before_full", LINE_W'(total), LINE_W'(8));
    chk("bankfull_both", {510'b0, bank_full}, LINE_W'(2'b11));

    // A line offered while not ready is dropped and the error sticks until flush.
    step(1'b1, LINE_W'(32'hDEAD), 1'b0, 1'b0, 1'b0, a);
    idle(3, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, a);
    idle(2, 1'b1);

    // Zero config maps to a full-depth tile played once.
    cfg_len = '0; cfg_rep = '0;
    for (int i = 0; i < DEPTH; i++) send(rnd_line(), 1'b1, n);
    idle(DEPTH + 4, 1'b1);

    // Reset in the middle of draining, then a clean refill.
    cfg_len = LEN_W'(4); cfg_rep = REP_W'(1);
    for (int i = 0; i < 4; i++) send(LINE_W'(32'hE0 + i), 1'b0, n);
    idle(2, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, a);
    chk("rst_bankfull", {510'b0, bank_full}, '0);
    for (int i = 0; i < 4; i++) send(LINE_W'(32'hF0 + i), 1'b1, n);
    idle(6, 1'b1);

    // Randomized traffic, config changes, occasional drops, flushes and resets.
    have = 1'b0;
    hold = '0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        cfg_len = LEN_W'($urandom_range(0, 6));
        cfg_rep = REP_W'($urandom_range(0, 3));
      end
      if (!have) begin
        hold = rnd_line();
        have = 1'b1;
      end
      step(($urandom_range(0, 7) != 0) && (pending < 2 || $urandom_range(0, 15) == 0),
           hold, $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0,
           $urandom_range(0, 299) == 0, a);
      if (a) have = 1'b0;
    end

    idle(120, 1'b1);
    chk("drained", LINE_W'(exp_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
